mmu_xlat_req: RTL

- CPU-side initiator for the MMU translation interface.
- Accepts one CPU bus-cycle request (VA, FC, R/W) at a time and presents it to the MMU with a level request strobe.
- Waits for hit or fault, bounded by a timeout, and returns a registered PA/fault response to the bus sequencer over a valid/ready handshake.
- FC=7 (CPU space) cycles bypass translation.

---
 rtl/mmu_xlat_req.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mmu_xlat_req.sv
// CPU-side initiator for the MMU translation interface: one request in flight at a time.
// Latency: 2+ cycles for translated accesses (accept -> mmu_req -> hit -> rsp), 1 cycle for FC=7 bypass.
// Backpressure: rsp_ready low holds the response indefinitely and keeps cpu_req_ready low.
module mmu_xlat_req #(
  parameter int VA_WIDTH       = 24,
  parameter int PA_WIDTH       = 24,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_WIDTH       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic [VA_WIDTH-1:0] cpu_va,
  input  logic [2:0]          cpu_fc,
  input  logic                cpu_rw_n,
  output logic                mmu_req,
  output logic [VA_WIDTH-1:0] mmu_va,
  output logic [2:0]          mmu_fc,
  output logic                mmu_rw_n,
  input  logic [PA_WIDTH-1:0] mmu_pa,
  input  logic                mmu_hit,
  input  logic                mmu_fault,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PA_WIDTH-1:0] rsp_pa,
  output logic                rsp_fault,
  output logic                rsp_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Common width used to zero-extend or truncate the VA onto the PA bus.
  localparam int XW = (PA_WIDTH > VA_WIDTH) ? PA_WIDTH : VA_WIDTH;
  localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [TO_WIDTH-1:0]   r_cnt;
  logic [VA_WIDTH-1:0]   r_va;
  logic [2:0]            r_fc;
  logic                  r_rw_n;
  logic [PA_WIDTH-1:0]   r_pa;
  logic                  r_fault;
  logic                  r_timeout;

  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_cnt_last;
  logic [XW-1:0]         w_va_ext;
  logic [PA_WIDTH-1:0]   w_bypass_pa;

  assign w_accept    = cpu_req_valid && (r_state == S_IDLE);
  assign w_bypass    = (cpu_fc == 3'b111);
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_va_ext    = XW'(cpu_va);
  assign w_bypass_pa = w_va_ext[PA_WIDTH-1:0];

  // State register; reset aborts any in-flight request without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: fault beats hit, hit beats timeout; MMU inputs only matter in WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_bypass ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mmu_fault || mmu_hit || w_cnt_last) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs decode directly from the registered state.
  always_comb begin
    cpu_req_ready = 1'b0;
    mmu_req       = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      S_IDLE:  cpu_req_ready = 1'b1;
      S_WAIT:  mmu_req       = 1'b1;
      S_RESP:  rsp_valid     = 1'b1;
      default: cpu_req_ready = 1'b0;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_va      <= '0;
      r_fc      <= 3'b000;
      r_rw_n    <= 1'b1;
      r_cnt     <= '0;
      r_pa      <= '0;
      r_fault   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_va   <= cpu_va;
            r_fc   <= cpu_fc;
            r_rw_n <= cpu_rw_n;
            r_cnt  <= '0;
            if (w_bypass) begin
              r_pa      <= w_bypass_pa;
              r_fault   <= 1'b0;
              r_timeout <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (mmu_fault) begin
            r_pa      <= '0;
            r_fault   <= 1'b1;
            r_timeout <= 1'b0;
          end else if (mmu_hit) begin
            r_pa      <= mmu_pa;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
          end else if (w_cnt_last) begin
            r_pa      <= '0;
            r_fault   <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // RESP: everything held until the consumer takes the response.
        end
      endcase
    end
  end

  assign mmu_va      = r_va;
  assign mmu_fc      = r_fc;
  assign mmu_rw_n    = r_rw_n;
  assign rsp_pa      = r_pa;
  assign rsp_fault   = r_fault;
  assign rsp_timeout = r_timeout;

endmodule
